// File: rtl/link_align_pkg.sv
// Shared types and constants for the link alignment controller.
package link_align_pkg;

   typedef enum logic [1:0] {
      StHunt   = 2'd0,
      StSlip   = 2'd1,
      StVerify = 2'd2,
      StLocked = 2'd3
   } align_state_e;

   localparam logic [7:0] K28_5 = 8'hBC;

endpackage

// File: rtl/link_align_ctrl_err_window_mon.sv
// LOCKED-state error window monitor: counts errored words per window of valid words
// and trips when the error count in one window reaches the threshold.
module err_window_mon #(
   parameter int unsigned ERR_WINDOW = 256,
   parameter int unsigned ERR_THRESH = 8
) (
   input  logic i_byteclk,
   input  logic i_rst,
   input  logic i_valid,
   input  logic i_err,
   input  logic i_clear,
   output logic o_trip
);

   localparam int unsigned CW = $clog2(ERR_WINDOW + 1);
   localparam int unsigned EW = $clog2(ERR_THRESH + 1);
   localparam logic [CW-1:0] WinLast  = CW'(ERR_WINDOW - 1);
   localparam logic [EW-1:0] ThreshM1 = EW'(ERR_THRESH - 1);

   logic [CW-1:0] r_win_cnt;
   logic [EW-1:0] r_win_err;

   // Checked against the pre-clear count, so the last word of a window can still trip.
   assign o_trip = i_valid & i_err & (r_win_err >= ThreshM1);

   always_ff @(posedge i_byteclk) begin
      if (i_rst || i_clear) begin
         r_win_cnt <= '0;
         r_win_err <= '0;
      end else if (i_valid) begin
         if (r_win_cnt == WinLast) begin
            r_win_cnt <= '0;
            r_win_err <= '0;
         end else begin
            r_win_cnt <= r_win_cnt + 1'b1;
            if (i_err) r_win_err <= r_win_err + 1'b1;
         end
      end
   end

endmodule

// File: rtl/link_align_ctrl.sv
// Comma-based word alignment controller with bitslip and loss-of-lock detection.
// Define LINK_ALIGN_STATS_EN to build the err_count/relock_count statistics counters.
module link_align_ctrl
   import link_align_pkg::*;
#(
   parameter logic [7:0]  COMMA_BYTE   = K28_5,
   parameter int unsigned LOCK_COUNT   = 4,
   parameter int unsigned HUNT_TIMEOUT = 64,
   parameter int unsigned SLIP_WAIT    = 12,
   parameter int unsigned ERR_WINDOW   = 256,
   parameter int unsigned ERR_THRESH   = 8
) (
   input  logic        i_byteclk,
   input  logic        i_rst,
   input  logic        i_rx_valid,
   input  logic [7:0]  i_rx_byte,
   input  logic        i_rx_isK,
   input  logic        i_rx_code_err,
   input  logic        i_rx_disp_err,
   output logic        o_bitslip,
   output logic        o_link_ok,
   output logic [1:0]  o_align_state,
   output logic [15:0] o_err_count,
   output logic [7:0]  o_relock_count
);

   localparam int unsigned HW = $clog2(HUNT_TIMEOUT + 1);
   localparam int unsigned LW = $clog2(LOCK_COUNT + 1);
   localparam int unsigned SW = $clog2(SLIP_WAIT + 1);
   localparam logic [HW-1:0] HuntLast = HW'(HUNT_TIMEOUT - 1);
   localparam logic [LW-1:0] LockLast = LW'(LOCK_COUNT - 1);
   localparam logic [SW-1:0] SlipLast = SW'(SLIP_WAIT - 1);

   align_state_e  r_state;
   logic [HW-1:0] r_hunt_cnt;
   logic [LW-1:0] r_comma_cnt;
   logic [SW-1:0] r_slip_cnt;
   logic          r_bitslip;
   logic          r_link_ok;

   logic w_word_err;
   logic w_comma;
   logic w_locked;
   logic w_trip;

   assign w_word_err = i_rx_valid & (i_rx_code_err | i_rx_disp_err);
   assign w_comma    = i_rx_valid & i_rx_isK & (i_rx_byte == COMMA_BYTE) & ~w_word_err;
   assign w_locked   = (r_state == StLocked);

   err_window_mon #(
      .ERR_WINDOW (ERR_WINDOW),
      .ERR_THRESH (ERR_THRESH)
   ) u_err_window_mon (
      .i_byteclk (i_byteclk),
      .i_rst     (i_rst),
      .i_valid   (w_locked & i_rx_valid),
      .i_err     (w_word_err),
      .i_clear   (~w_locked),
      .o_trip    (w_trip)
   );

   always_ff @(posedge i_byteclk) begin
      if (i_rst) begin
         r_state     <= StHunt;
         r_hunt_cnt  <= '0;
         r_comma_cnt <= '0;
         r_slip_cnt  <= '0;
         r_bitslip   <= 1'b0;
         r_link_ok   <= 1'b0;
      end else begin
         r_bitslip <= 1'b0;
         unique case (r_state)
            StHunt: begin
               if (w_comma) begin
                  r_state     <= StVerify;
                  r_comma_cnt <= LW'(1);
                  r_hunt_cnt  <= '0;
               end else if (i_rx_valid) begin
                  if (r_hunt_cnt == HuntLast) begin
                     r_state    <= StSlip;
                     r_bitslip  <= 1'b1;
                     r_slip_cnt <= '0;
                     r_hunt_cnt <= '0;
                  end else begin
                     r_hunt_cnt <= r_hunt_cnt + 1'b1;
                  end
               end
            end
            StSlip: begin
               // Deserializer settles here; rx inputs are deliberately ignored.
               if (r_slip_cnt == SlipLast) begin
                  r_state    <= StHunt;
                  r_hunt_cnt <= '0;
               end else begin
                  r_slip_cnt <= r_slip_cnt + 1'b1;
               end
            end
            StVerify: begin
               if (w_word_err) begin
                  r_state    <= StSlip;
                  r_bitslip  <= 1'b1;
                  r_slip_cnt <= '0;
               end else if (w_comma) begin
                  if (r_comma_cnt == LockLast) begin
                     r_state   <= StLocked;
                     r_link_ok <= 1'b1;
                  end else begin
                     r_comma_cnt <= r_comma_cnt + 1'b1;
                  end
               end
            end
            StLocked: begin
               if (w_trip) begin
                  r_state    <= StHunt;
                  r_link_ok  <= 1'b0;
                  r_hunt_cnt <= '0;
               end
            end
            default: r_state <= StHunt;
         endcase
      end
   end

   assign o_bitslip     = r_bitslip;
   assign o_link_ok     = r_link_ok;
   assign o_align_state = r_state;

`ifdef LINK_ALIGN_STATS_EN
   logic [15:0] r_err_count;
   logic [7:0]  r_relock_count;

   always_ff @(posedge i_byteclk) begin
      if (i_rst) begin
         r_err_count    <= '0;
         r_relock_count <= '0;
      end else begin
         if (w_locked && w_word_err && (r_err_count != '1)) r_err_count <= r_err_count + 1'b1;
         if (w_locked && w_trip && (r_relock_count != '1)) begin
            r_relock_count <= r_relock_count + 1'b1;
         end
      end
   end

   assign o_err_count    = r_err_count;
   assign o_relock_count = r_relock_count;
`else
   assign o_err_count    = '0;
   assign o_relock_count = '0;
`endif

endmodule
